// File: rtl/s_axil_pkg.sv
// Shared response codes, lane/index helpers and the strobe-to-mask function
// for the AXI4-Lite register file.
package s_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_LANES      = MAX_DATA_WIDTH / 8;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte inside one register.
  function automatic int idx_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] strb_to_mask(input logic [MAX_LANES-1:0] strb);
    logic [MAX_DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/s_axil_hold_reg.sv
// One-entry valid/ready holding register: accepts when empty, holds until
// the consumer clears it.
module s_axil_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

  // Load and clear never coincide: clear only happens while full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (valid_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/s_axil_regfile.sv
// Parametrised AXI4-Lite register file with RO status registers and
// per-register strobes. Define S_AXIL_REGFILE_SLVERR_EN for SLVERR responses.
module s_axil_regfile
  import s_axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int LANES = byte_lanes(DATA_WIDTH);
  localparam int LSB   = idx_lsb(DATA_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - LSB;

  logic                    aw_full, w_full, commit;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH+LANES-1:0] w_pack;
  logic [DATA_WIDTH-1:0]   w_data, wmask;
  logic [LANES-1:0]        w_strb;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [NUM_REGS-1:0]     wr_hit, rd_hit, wr_en;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rd_val;
  logic [1:0]              bresp_d, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic                    ar_hs;

  logic                    bvalid_q, rvalid_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [NUM_REGS-1:0]     wr_pulse_q, rd_pulse_q;

  s_axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk_i(ACLK), .rst_ni(ARESETN), .valid_i(AWVALID), .ready_o(AWREADY),
    .data_i(AWADDR), .clr_i(commit), .full_o(aw_full), .data_o(aw_addr)
  );

  s_axil_hold_reg #(.WIDTH(DATA_WIDTH+LANES)) u_w_hold (
    .clk_i(ACLK), .rst_ni(ARESETN), .valid_i(WVALID), .ready_o(WREADY),
    .data_i({WSTRB, WDATA}), .clr_i(commit), .full_o(w_full), .data_o(w_pack)
  );

  assign w_data = w_pack[DATA_WIDTH-1:0];
  assign w_strb = w_pack[DATA_WIDTH +: LANES];
  assign wmask  = DATA_WIDTH'(strb_to_mask(MAX_LANES'(w_strb)));

  // Holding a finished response blocks the next commit until B drains.
  assign commit = aw_full && w_full && (!bvalid_q || BREADY);
  assign wr_idx = aw_addr[ADDR_WIDTH-1:LSB];
  assign rd_idx = ARADDR[ADDR_WIDTH-1:LSB];
  assign wr_en  = wr_hit & ~RO_MASK;

  assign ARREADY = !rvalid_q || RREADY;
  assign ar_hs   = ARVALID && ARREADY;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{aw_addr[LSB-1:0], ARADDR[LSB-1:0]};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wr_hit[i] = (wr_idx == IDX_W'(i));
    assign rd_hit[i] = (rd_idx == IDX_W'(i));
    if (RO_MASK[i]) begin : g_ro
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      assign rd_val[i] = status_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_q;
      logic unused_status;
      assign unused_status = ^status_in[i*DATA_WIDTH +: DATA_WIDTH];
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                  r_q <= RESET_VALUE;
        else if (commit && wr_hit[i])  r_q <= (r_q & ~wmask) | (w_data & wmask);
      end
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r_q;
      assign rd_val[i] = r_q;
    end
  end

  // Out-of-range reads fall through to zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) if (rd_hit[i]) rdata_d = rd_val[i];
  end

`ifdef S_AXIL_REGFILE_SLVERR_EN
  assign bresp_d = (|wr_en)  ? RESP_OKAY : RESP_SLVERR;
  assign rresp_d = (|rd_hit) ? RESP_OKAY : RESP_SLVERR;
`else
  assign bresp_d = RESP_OKAY;
  assign rresp_d = RESP_OKAY;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= commit ? wr_en : '0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // RDATA samples the register before a same-edge commit lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      rd_pulse_q <= ar_hs ? rd_hit : '0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_s_axil_regfile.sv
// Randomised self-checking bench for s_axil_regfile against a byte-level
// reference model of the register file.
module tb_s_axil_regfile;

  localparam logic [15:0] RO = 16'h0008;
  localparam logic [31:0] RV = 32'h0BAD_F00D;
`ifdef S_AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] SLV = 2'b10;
`else
  localparam logic [1:0] SLV = 2'b00;
`endif

  logic         ACLK, ARESETN;
  logic [7:0]   AWADDR, ARADDR;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;
  logic [511:0] reg_out, status_in;
  logic [15:0]  wr_pulse, rd_pulse;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mdl [16];

  s_axil_regfile #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .RO_MASK(RO), .RESET_VALUE(RV)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .status_in(status_in),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic bit is_rw(input logic [7:0] a);
    int idx = int'(a[7:2]);
    logic [15:0] ro = RO;
    if (idx >= 16) return 1'b0;
    return !ro[idx];
  endfunction

  task automatic mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (is_rw(a)) mdl[int'(a[7:2])] = merge(mdl[int'(a[7:2])], d, s);
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = RV;
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    int idx = int'(a[7:2]);
    logic [15:0] ro = RO;
    if (idx >= 16) return 32'h0;
    if (ro[idx]) return status_in[idx*32 +: 32];
    return mdl[idx];
  endfunction

  function automatic logic [15:0] exp_pulse(input logic [7:0] a, input bit wr);
    int idx = int'(a[7:2]);
    if (idx >= 16) return 16'h0;
    if (wr && !is_rw(a)) return 16'h0;
    return 16'(1) << idx;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [7:0] a, input bit wr);
    if (int'(a[7:2]) >= 16) return SLV;
    if (wr && !is_rw(a)) return SLV;
    return 2'b00;
  endfunction

  function automatic logic [511:0] exp_regs();
    logic [511:0] v = '0;
    logic [15:0] ro = RO;
    for (int i = 0; i < 16; i++) if (!ro[i]) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  function automatic logic [511:0] rw_mask();
    logic [511:0] v = '0;
    logic [15:0] ro = RO;
    for (int i = 0; i < 16; i++) if (!ro[i]) v[i*32 +: 32] = '1;
    return v;
  endfunction

  // ---------------- bus drivers (no checking) ----------------
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [15:0] pul,
                           output logic [15:0] pul_next, output int lat);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin aw_done = 1; AWVALID = 0; end
      if (w_hs)  begin w_done = 1;  WVALID = 0;  end
      n++;
    end
    lat = 0;
    if (aw_done && w_done) begin
      do begin @(negedge ACLK); lat++; end while (!BVALID && lat < 20);
      resp = BRESP; pul = wr_pulse;
      @(posedge ACLK); #1;
      @(negedge ACLK); pul_next = wr_pulse;
    end else begin
      lat = -1; resp = 2'b11; pul = '1; pul_next = '1;
      AWVALID = 0; WVALID = 0;
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output logic [15:0] pul, output bit ok);
    bit hs = 0;
    int n = 0;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    while (!hs && n < 20) begin
      hs = ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    ARVALID = 0;
    @(negedge ACLK);
    ok = hs && RVALID; data = RDATA; resp = RRESP; pul = rd_pulse;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ARESETN = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    vectors++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      miscompares++; $display("FAIL reset_handshake got %b want 11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    vectors++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      miscompares++; $display("FAIL reset_resp_data got %h want 0", {BRESP, RRESP, RDATA});
    end
    vectors++;
    if ({wr_pulse, rd_pulse} !== 32'h0) begin
      miscompares++; $display("FAIL reset_pulses got %h want 0", {wr_pulse, rd_pulse});
    end
    mdl_reset();
    vectors++;
    if ((reg_out & rw_mask()) !== exp_regs()) begin
      miscompares++; $display("FAIL reset_regs reg0 got %h want %h", reg_out[31:0], RV);
    end
    ARESETN = 1;
    @(negedge ACLK);
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [15:0] p, pn; int lat; logic [31:0] d; bit ok;
    axi_write(8'h08, 32'hDEADBEEF, 4'hF, r, p, pn, lat);
    mdl_write(8'h08, 32'hDEADBEEF, 4'hF);
    vectors++; if (r !== 2'b00) begin miscompares++; $display("FAIL basic_bresp got %b want 00", r); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL basic_latency got %0d want 2", lat); end
    vectors++; if (p !== exp_pulse(8'h08, 1)) begin miscompares++; $display("FAIL basic_wr_pulse got %h want %h", p, exp_pulse(8'h08, 1)); end
    vectors++; if (pn !== 16'h0) begin miscompares++; $display("FAIL basic_wr_pulse_width got %h want 0", pn); end
    vectors++; if (reg_out[2*32 +: 32] !== mdl[2]) begin miscompares++; $display("FAIL basic_reg2 got %h want %h", reg_out[2*32 +: 32], mdl[2]); end
    axi_read(8'h08, d, r, p, ok);
    vectors++; if (!ok || d !== exp_read(8'h08)) begin miscompares++; $display("FAIL basic_rdata got %h want %h", d, exp_read(8'h08)); end
    vectors++; if (p !== exp_pulse(8'h08, 0)) begin miscompares++; $display("FAIL basic_rd_pulse got %h want %h", p, exp_pulse(8'h08, 0)); end
  endtask

  task automatic test_w_before_aw();
    @(negedge ACLK);
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1; BREADY = 1;
    vectors++; if (WREADY !== 1'b1) begin miscompares++; $display("FAIL wfirst_wready got %b want 1", WREADY); end
    @(posedge ACLK); #1; WVALID = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      vectors++;
      if ({WREADY, BVALID, wr_pulse} !== 18'h0) begin
        miscompares++; $display("FAIL wfirst_held c%0d got wready=%b bvalid=%b pulse=%h want 0", c, WREADY, BVALID, wr_pulse);
      end
    end
    AWADDR = 8'h08; AWVALID = 1;
    vectors++; if (AWREADY !== 1'b1) begin miscompares++; $display("FAIL wfirst_awready got %b want 1", AWREADY); end
    @(posedge ACLK); #1; AWVALID = 0;
    @(negedge ACLK);
    vectors++; if (BVALID !== 1'b0) begin miscompares++; $display("FAIL wfirst_early_bvalid got %b want 0", BVALID); end
    @(negedge ACLK);
    mdl_write(8'h08, 32'h11223344, 4'b0101);
    vectors++; if (BVALID !== 1'b1) begin miscompares++; $display("FAIL wfirst_bvalid got %b want 1", BVALID); end
    vectors++; if (wr_pulse !== exp_pulse(8'h08, 1)) begin miscompares++; $display("FAIL wfirst_pulse got %h want %h", wr_pulse, exp_pulse(8'h08, 1)); end
    vectors++; if (reg_out[2*32 +: 32] !== mdl[2]) begin miscompares++; $display("FAIL wfirst_merge got %h want %h", reg_out[2*32 +: 32], mdl[2]); end
    @(posedge ACLK); #1;
    @(negedge ACLK);
  endtask

  task automatic test_ro();
    logic [1:0] r; logic [15:0] p, pn; int lat; logic [31:0] d; bit ok;
    status_in[3*32 +: 32] = 32'hA5A5A5A5;
    axi_read(8'h0C, d, r, p, ok);
    vectors++; if (!ok || d !== exp_read(8'h0C)) begin miscompares++; $display("FAIL ro_rdata got %h want %h", d, exp_read(8'h0C)); end
    vectors++; if (p !== exp_pulse(8'h0C, 0)) begin miscompares++; $display("FAIL ro_rd_pulse got %h want %h", p, exp_pulse(8'h0C, 0)); end
    axi_write(8'h0C, 32'h5A5A1234, 4'hF, r, p, pn, lat);
    mdl_write(8'h0C, 32'h5A5A1234, 4'hF);
    vectors++; if (r !== exp_resp(8'h0C, 1)) begin miscompares++; $display("FAIL ro_bresp got %b want %b", r, exp_resp(8'h0C, 1)); end
    vectors++; if (p !== 16'h0) begin miscompares++; $display("FAIL ro_wr_pulse got %h want 0", p); end
    vectors++; if ((reg_out & rw_mask()) !== exp_regs()) begin miscompares++; $display("FAIL ro_regs_changed"); end
  endtask

  task automatic test_oor();
    logic [1:0] r; logic [15:0] p, pn; int lat; logic [31:0] d; bit ok;
    axi_read(8'h40, d, r, p, ok);
    vectors++; if (!ok || d !== 32'h0) begin miscompares++; $display("FAIL oor_rdata got %h want 0", d); end
    vectors++; if (r !== exp_resp(8'h40, 0)) begin miscompares++; $display("FAIL oor_rresp got %b want %b", r, exp_resp(8'h40, 0)); end
    vectors++; if (p !== 16'h0) begin miscompares++; $display("FAIL oor_rd_pulse got %h want 0", p); end
    axi_write(8'h40, 32'hFFFFFFFF, 4'hF, r, p, pn, lat);
    vectors++; if (r !== exp_resp(8'h40, 1)) begin miscompares++; $display("FAIL oor_bresp got %b want %b", r, exp_resp(8'h40, 1)); end
    vectors++; if (p !== 16'h0) begin miscompares++; $display("FAIL oor_wr_pulse got %h want 0", p); end
    vectors++; if ((reg_out & rw_mask()) !== exp_regs()) begin miscompares++; $display("FAIL oor_regs_changed"); end
  endtask

  task automatic test_rready_stall();
    logic [7:0] seq [6] = '{8'h10, 8'h14, 8'h00, 8'h0C, 8'h44, 8'h08};
    logic [31:0] hold;
    @(negedge ACLK);
    ARADDR = 8'h08; ARVALID = 1; RREADY = 0;
    hold = exp_read(8'h08);
    vectors++; if (ARREADY !== 1'b1) begin miscompares++; $display("FAIL stall_arready_idle got %b want 1", ARREADY); end
    @(posedge ACLK); #1;
    ARADDR = seq[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      vectors++;
      if ({RVALID, ARREADY} !== 2'b10 || RDATA !== hold) begin
        miscompares++; $display("FAIL stall_c%0d got rvalid=%b arready=%b rdata=%h want 1 0 %h", c, RVALID, ARREADY, RDATA, hold);
      end
    end
    RREADY = 1;
    for (int j = 0; j < 6; j++) begin
      @(posedge ACLK); #1;
      if (j < 5) ARADDR = seq[j+1]; else ARVALID = 0;
      @(negedge ACLK);
      vectors++;
      if (RVALID !== 1'b1 || RDATA !== exp_read(seq[j]) || rd_pulse !== exp_pulse(seq[j], 0)) begin
        miscompares++; $display("FAIL b2b_read%0d got v=%b d=%h p=%h want 1 %h %h", j, RVALID, RDATA, rd_pulse, exp_read(seq[j]), exp_pulse(seq[j], 0));
      end
    end
    @(posedge ACLK); #1;
    @(negedge ACLK);
    vectors++; if (RVALID !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", RVALID); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d = $urandom;
    int cnt = 0;
    @(negedge ACLK);
    AWADDR = 8'h18; WDATA = d; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      cnt += int'(wr_pulse[6]);
    end
    AWVALID = 0; WVALID = 0;
    mdl_write(8'h18, d, 4'hF);
    vectors++; if (cnt !== 5) begin miscompares++; $display("FAIL b2b_write_rate got %0d want 5", cnt); end
    vectors++; if (reg_out[6*32 +: 32] !== mdl[6]) begin miscompares++; $display("FAIL b2b_write_reg got %h want %h", reg_out[6*32 +: 32], mdl[6]); end
    @(posedge ACLK); #1;
    @(negedge ACLK);
  endtask

  task automatic test_collision();
    logic [31:0] d = $urandom;
    logic [31:0] old = exp_read(8'h14);
    @(negedge ACLK);
    AWADDR = 8'h14; WDATA = d; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARADDR = 8'h14; ARVALID = 1; RREADY = 1;
    @(posedge ACLK); #1;
    ARVALID = 0;
    mdl_write(8'h14, d, 4'hF);
    @(negedge ACLK);
    vectors++; if (RVALID !== 1'b1 || RDATA !== old) begin miscompares++; $display("FAIL collide_rdata got %h want %h", RDATA, old); end
    vectors++; if (BVALID !== 1'b1 || reg_out[5*32 +: 32] !== mdl[5]) begin miscompares++; $display("FAIL collide_write got %h want %h", reg_out[5*32 +: 32], mdl[5]); end
    @(posedge ACLK); #1;
    @(negedge ACLK);
  endtask

  task automatic test_random();
    logic [1:0] r; logic [15:0] p, pn; int lat; logic [31:0] d, wd; bit ok;
    logic [7:0] a; logic [3:0] s;
    for (int it = 0; it < 40; it++) begin
      a = {2'(0), 6'($urandom_range(0, 19))} << 2;
      a = a | 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, wd, s, r, p, pn, lat);
        mdl_write(a, wd, s);
        vectors++;
        if (lat !== 2 || r !== exp_resp(a, 1) || p !== exp_pulse(a, 1) || (reg_out & rw_mask()) !== exp_regs()) begin
          miscompares++; $display("FAIL rand_write%0d a=%h lat=%0d resp=%b/%b pulse=%h/%h", it, a, lat, r, exp_resp(a, 1), p, exp_pulse(a, 1));
        end
      end else begin
        status_in[3*32 +: 32] = $urandom;
        axi_read(a, d, r, p, ok);
        vectors++;
        if (!ok || d !== exp_read(a) || r !== exp_resp(a, 0) || p !== exp_pulse(a, 0)) begin
          miscompares++; $display("FAIL rand_read%0d a=%h data=%h/%h resp=%b/%b pulse=%h/%h", it, a, d, exp_read(a), r, exp_resp(a, 0), p, exp_pulse(a, 0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    AWADDR = 8'h1C; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    @(posedge ACLK); #1;
    AWADDR = 8'h20; AWVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0;
    @(negedge ACLK);
    vectors++; if ({BVALID, AWREADY} !== 2'b10) begin miscompares++; $display("FAIL rstmid_setup got bvalid=%b awready=%b want 1 0", BVALID, AWREADY); end
    #2 ARESETN = 0;
    #1;
    mdl_reset();
    vectors++; if ({BVALID, AWREADY} !== 2'b01) begin miscompares++; $display("FAIL rstmid_async got bvalid=%b awready=%b want 0 1", BVALID, AWREADY); end
    vectors++; if ((reg_out & rw_mask()) !== exp_regs()) begin miscompares++; $display("FAIL rstmid_regs reg7 got %h want %h", reg_out[7*32 +: 32], RV); end
    @(negedge ACLK);
    ARESETN = 1; BREADY = 1;
    WDATA = 32'h12345678; WVALID = 1;
    @(posedge ACLK); #1;
    WVALID = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      vectors++;
      if (BVALID !== 1'b0 || wr_pulse !== 16'h0 || (reg_out & rw_mask()) !== exp_regs()) begin
        miscompares++; $display("FAIL rstmid_nocommit c%0d bvalid=%b pulse=%h", c, BVALID, wr_pulse);
      end
    end
  endtask

  initial begin
    ARESETN = 0; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < 16; i++) status_in[i*32 +: 32] = $urandom;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_ro();
    test_oor();
    test_rready_stall();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/s_axil_regfile.md
# s_axil_regfile

Parametrised AXI4-Lite slave register file, the next generation of the fixed 16×32 register slave. It has a configurable register count and data width, per-register read-only status inputs, and per-register write/read strobes toward user logic. The AW and W channels are accepted independently, so they may arrive in either order. It sits between the AXI-Lite interconnect and a peripheral's control/status logic.

## Interface
- `ADDR_WIDTH`, 8: byte address width.
- `DATA_WIDTH`, 32: 32 or 64. Byte lanes are `DATA_WIDTH/8`.
- `NUM_REGS`, 16: 1 to 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- `RO_MASK`, 0: `NUM_REGS`-bit mask. A set bit makes that register read-only; it reads from `status_in`.
- `RESET_VALUE`, 0: reset value of every RW register.
- `ACLK` in 1: single clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `AWADDR` in ADDR_WIDTH, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in DATA_WIDTH, `WSTRB` in DATA_WIDTH/8, `WVALID` in 1, `WREADY` out 1: write data channel.
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel.
- `ARADDR` in ADDR_WIDTH, `ARVALID` in 1, `ARREADY` out 1: read address channel.
- `RDATA` out DATA_WIDTH, `RRESP` out 2, `RVALID` out 1, `RREADY` in 1: read data channel.
- `reg_out` out NUM_REGS×DATA_WIDTH: flattened RW register contents. Register i is at bits [i×DATA_WIDTH +: DATA_WIDTH].
- `status_in` in NUM_REGS×DATA_WIDTH: read values for RO registers. Slices of RW registers are ignored.
- `wr_pulse` out NUM_REGS: one-cycle pulse per committed write to register i.
- `rd_pulse` out NUM_REGS: one-cycle pulse per accepted read of register i.

## Operation
- Address decode:
  - index = addr[ADDR_WIDTH−1 : log2(DATA_WIDTH/8)]. Low address bits are ignored.
  - index ≥ NUM_REGS is out-of-range.
- Write path:
  - AW and W each have a one-entry holding register.
  - AWREADY = !aw_full and WREADY = !w_full, independent of each other.
- Write commit:
  - Condition: aw_full && w_full && (!BVALID || BREADY).
  - RW in-range target: bytes with WSTRB set are updated; other bytes are kept.
  - RO or out-of-range target: the write is dropped.
  - Commit clears both holding registers and sets BVALID.
  - `wr_pulse[index]` is asserted only for an in-range RW target.
- BVALID is held until BREADY. It is cleared on handshake unless a new commit happens in the same cycle.
- Read path:
  - ARREADY = !RVALID || RREADY.
  - On AR handshake, RDATA is registered: RW regs give the register value, RO regs give the `status_in` slice, out-of-range gives 0.
  - RVALID is set on AR handshake and `rd_pulse[index]` fires in-range.
  - RDATA/RRESP are stable while RVALID && !RREADY.
- Simultaneous events:
  - Read and write commit to the same register in the same cycle: the read returns the pre-write value.
  - New AW/W handshakes are accepted while BVALID is pending, one entry deep each.
- BRESP/RRESP are OKAY (2'b00) unless `S_AXIL_REGFILE_SLVERR_EN` applies.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - AWREADY=WREADY=ARREADY=1.
  - BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
  - wr_pulse=rd_pulse=0, RW registers=RESET_VALUE.
- Reset mid-transaction: held AW/W are discarded and pending B/R responses are dropped without handshake.
- Write: last of the AW/W handshakes at edge k → commit at edge k+1 → BVALID high after edge k+1. Register update and `wr_pulse` are visible in the same cycle as BVALID.
- Read: AR handshake at edge k → RVALID, RDATA and `rd_pulse` are valid after edge k.
- Sustained reads with RREADY=1 run at 1 per cycle. Sustained writes with BREADY=1 run at 1 per 2 cycles.
- VALID outputs never depend combinationally on READY inputs.

## Configuration
- `S_AXIL_REGFILE_SLVERR_EN` defined:
  - Out-of-range write or write to an RO register → BRESP=SLVERR (2'b10).
  - Out-of-range read → RRESP=SLVERR, RDATA=0.
- Not defined: all responses are OKAY. Dropped writes and zero read data behave the same as with the macro.

## Structure
- Package `s_axil_pkg` holds:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Byte-lane and index-width localparams.
  - The strobe-to-bit-mask function.
- Sub-module `s_axil_hold_reg` is a one-entry valid/ready holding register, parametrised by width. It is instantiated once for AW and once for W.

## Test plan
- Reset defaults, NUM_REGS=16, DATA_WIDTH=32: write 0xDEADBEEF to 0x08, WSTRB=4'hF → BRESP=OKAY, reg_out[2]=0xDEADBEEF, wr_pulse[2] for 1 cycle. Read 0x08 → RDATA=0xDEADBEEF.
- W presented 3 cycles before AW: WREADY high, the write is held, then commits 1 cycle after the AW handshake. Write 0x11223344 with WSTRB=4'b0101 over 0xDEADBEEF → 0xDE22BE44.
- RO_MASK bit 3 set, status_in[3]=0xA5A5A5A5: read 0x0C → 0xA5A5A5A5 with rd_pulse[3]. Write 0x0C → register unchanged, no wr_pulse, BRESP=SLVERR with the macro and OKAY without.
- Read 0x40 with NUM_REGS=16 → RDATA=0, RRESP=SLVERR with the macro. Write 0x40 → no register changes.
- RREADY low for 5 cycles during a read: RVALID/RDATA stay stable and ARREADY stays low. Back-to-back reads with RREADY=1 complete 1 per cycle.
- Deassert ARESETN while BVALID=1 and a second AW is held → BVALID=0 immediately, no commit, registers=RESET_VALUE.
